// File: rtl/fib_step_sequencer.sv
// -----------------------------------------------------------------------------
// fib_step_sequencer
//
// Run-control sequencer for the Fibonacci datapath. Converts the programmed
// run switch and step period into single-cycle step / clear pulses for the
// Fibonacci core, supports free-run, paused single-stepping, overflow halt and
// restart, counts issued steps (saturating) and snapshots the core value once
// it has absorbed each step.
//
// Ports
//   wb_clk_i     system clock, rising edge
//   reset_n      asynchronous active-low reset
//   switch_in    run switch (1 = free-run, 0 = pause)
//   clock_op     step period in clocks, 0 = no automatic steps
//   single_step  one-cycle step request, honoured only while paused
//   restart      one-cycle request to clear the core and counters
//   fib_val      current core value
//   fib_ovf      core flag: the next step would overflow
//   fib_step     one-cycle pulse, core advances one term
//   fib_clear    one-cycle pulse, core reloads its seed
//   busy         high while free-running
//   halted       high while halted on overflow
//   step_count   steps issued since the last clear (saturating)
//   val_snap     core value captured after the most recent step
//   snap_valid   one-cycle pulse when val_snap updates
// -----------------------------------------------------------------------------
module fib_step_sequencer #(
  parameter int CLOCK_WIDTH = 6,
  parameter int VAL_WIDTH   = 30,
  parameter int STEP_WIDTH  = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   reset_n,
  input  logic                   switch_in,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  input  logic                   single_step,
  input  logic                   restart,
  input  logic [VAL_WIDTH-1:0]   fib_val,
  input  logic                   fib_ovf,
  output logic                   fib_step,
  output logic                   fib_clear,
  output logic                   busy,
  output logic                   halted,
  output logic [STEP_WIDTH-1:0]  step_count,
  output logic [VAL_WIDTH-1:0]   val_snap,
  output logic                   snap_valid
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [STEP_WIDTH-1:0]  STEP_MAX  = {STEP_WIDTH{1'b1}};
  localparam logic [STEP_WIDTH-1:0]  STEP_ZERO = {STEP_WIDTH{1'b0}};
  localparam logic [STEP_WIDTH-1:0]  STEP_ONE  = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CLOCK_WIDTH-1:0] DIV_ZERO  = {CLOCK_WIDTH{1'b0}};
  localparam logic [CLOCK_WIDTH-1:0] DIV_ONE   = {{(CLOCK_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [VAL_WIDTH-1:0]   VAL_ZERO  = {VAL_WIDTH{1'b0}};

  state_e                  state_q, state_d;
  logic [CLOCK_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic                    fib_step_q, fib_step_d;
  logic                    fib_clear_q, fib_clear_d;
  logic                    busy_q, busy_d;
  logic                    halted_q, halted_d;
  logic [STEP_WIDTH-1:0]   step_count_q, step_count_d;
  logic [VAL_WIDTH-1:0]    val_snap_q, val_snap_d;
  logic                    snap_valid_q, snap_valid_d;
  logic                    snap_pend_q, snap_pend_d;

  logic [CLOCK_WIDTH:0]    div_next_s;
  logic                    tick_s;

  // Compare div_cnt+1 >= clock_op instead of div_cnt >= clock_op-1 so the
  // subtraction can never wrap; a lowered period fires on the next cycle.
  assign div_next_s = {1'b0, div_cnt_q} + {1'b0, DIV_ONE};
  assign tick_s     = (clock_op != DIV_ZERO) && (div_next_s >= {1'b0, clock_op});

  // Next-state, divider and step/clear pulse decisions.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    fib_step_d  = 1'b0;
    fib_clear_d = 1'b0;
    if (restart) begin
      // Restart beats everything; any step decided this cycle is dropped.
      state_d     = ST_CLEAR;
      div_cnt_d   = DIV_ZERO;
      fib_clear_d = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          div_cnt_d = DIV_ZERO;
          if (!fib_clear_q) begin
            // Fresh out of reset the clear pulse has not been issued yet:
            // spend one more cycle in CLEAR to emit it.
            state_d     = ST_CLEAR;
            fib_clear_d = 1'b1;
          end else if (switch_in) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (!switch_in) begin
            state_d   = ST_PAUSE;
            div_cnt_d = DIV_ZERO;
          end else if (clock_op == DIV_ZERO) begin
            div_cnt_d = DIV_ZERO;
          end else if (tick_s) begin
            div_cnt_d = DIV_ZERO;
            if (fib_ovf) begin
              state_d = ST_HALT;
            end else begin
              fib_step_d = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
          end
        end
        ST_PAUSE: begin
          div_cnt_d = DIV_ZERO;
          if (switch_in) begin
            state_d = ST_RUN;
          end else if (single_step) begin
            if (fib_ovf) begin
              state_d = ST_HALT;
            end else begin
              fib_step_d = 1'b1;
            end
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_HALT: begin
          div_cnt_d = DIV_ZERO;
          state_d   = ST_HALT;
        end
        default: begin
          state_d     = ST_CLEAR;
          div_cnt_d   = DIV_ZERO;
          fib_clear_d = 1'b1;
        end
      endcase
    end
  end

  // Step counter, snapshot pipeline and status flags.
  always_comb begin
    step_count_d = step_count_q;
    val_snap_d   = val_snap_q;
    snap_valid_d = 1'b0;
    // The core absorbs a step at the edge that ends the fib_step cycle, so
    // the value is captured one cycle later; entering CLEAR cancels it.
    snap_pend_d  = fib_step_q && (state_d != ST_CLEAR);
    busy_d       = (state_d == ST_RUN);
    halted_d     = (state_d == ST_HALT);
    if (state_d == ST_CLEAR) begin
      step_count_d = STEP_ZERO;
      val_snap_d   = VAL_ZERO;
      snap_valid_d = 1'b0;
    end else begin
      if (fib_step_d && (step_count_q != STEP_MAX)) begin
        step_count_d = step_count_q + STEP_ONE;
      end else begin
        step_count_d = step_count_q;
      end
      if (snap_pend_q) begin
        val_snap_d   = fib_val;
        snap_valid_d = 1'b1;
      end else begin
        val_snap_d   = val_snap_q;
        snap_valid_d = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      div_cnt_q    <= DIV_ZERO;
      fib_step_q   <= 1'b0;
      fib_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      step_count_q <= STEP_ZERO;
      val_snap_q   <= VAL_ZERO;
      snap_valid_q <= 1'b0;
      snap_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      fib_step_q   <= fib_step_d;
      fib_clear_q  <= fib_clear_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      step_count_q <= step_count_d;
      val_snap_q   <= val_snap_d;
      snap_valid_q <= snap_valid_d;
      snap_pend_q  <= snap_pend_d;
    end
  end

  assign fib_step   = fib_step_q;
  assign fib_clear  = fib_clear_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign step_count = step_count_q;
  assign val_snap   = val_snap_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_fib_step_sequencer.sv
// Testbench for fib_step_sequencer with a model Fibonacci core seeded (0,1).
module tb_fib_step_sequencer;
  localparam int CW = 6;
  localparam int VW = 30;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sw, ss, rs;
  logic [CW-1:0] cop;
  logic [VW-1:0] core_a, core_b;
  logic          core_ovf;
  logic          f_step, f_clear, busy, halted, snap_valid;
  logic [SW-1:0] step_count;
  logic [VW-1:0] val_snap;

  logic          rst4_n, sw4, ss4, rs4, ovf4;
  logic [CW-1:0] cop4;
  logic [VW-1:0] val4;
  logic          f_step4, f_clear4, busy4, halted4, snap_valid4;
  logic [3:0]    step_count4;
  logic [VW-1:0] val_snap4;

  int compared = 0;
  int mismatched = 0;
  longint exp_q[$];

  fib_step_sequencer #(.CLOCK_WIDTH(CW), .VAL_WIDTH(VW), .STEP_WIDTH(SW)) dut (
    .wb_clk_i(clk), .reset_n(rst_n), .switch_in(sw), .clock_op(cop),
    .single_step(ss), .restart(rs), .fib_val(core_b), .fib_ovf(core_ovf),
    .fib_step(f_step), .fib_clear(f_clear), .busy(busy), .halted(halted),
    .step_count(step_count), .val_snap(val_snap), .snap_valid(snap_valid));

  fib_step_sequencer #(.CLOCK_WIDTH(CW), .VAL_WIDTH(VW), .STEP_WIDTH(4)) dut4 (
    .wb_clk_i(clk), .reset_n(rst4_n), .switch_in(sw4), .clock_op(cop4),
    .single_step(ss4), .restart(rs4), .fib_val(val4), .fib_ovf(ovf4),
    .fib_step(f_step4), .fib_clear(f_clear4), .busy(busy4), .halted(halted4),
    .step_count(step_count4), .val_snap(val_snap4), .snap_valid(snap_valid4));

  // Model core: pair (a,b), output b, overflow flag when a+b exceeds VW bits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a <= {VW{1'b0}};
      core_b <= {{(VW-1){1'b0}}, 1'b1};
    end else if (f_clear) begin
      core_a <= {VW{1'b0}};
      core_b <= {{(VW-1){1'b0}}, 1'b1};
    end else if (f_step) begin
      core_a <= core_b;
      core_b <= core_a + core_b;
    end
  end
  assign core_ovf = ({1'b0, core_a} + {1'b0, core_b}) > {1'b0, {VW{1'b1}}};

  function automatic longint fib(input int n);
    longint x, y, t;
    x = 0; y = 1;
    for (int i = 0; i < n; i++) begin t = x + y; x = y; y = t; end
    return x;
  endfunction

  task automatic test_reset();
    int step_q[$];
    int e;
    rst_n = 1'b0; sw = 1'b1; cop = 6'd3; ss = 1'b0; rs = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if ({f_step, f_clear, busy, halted, snap_valid} !== 5'b0) begin mismatched++; $display("FAIL reset_flags: got %b expected 00000", {f_step, f_clear, busy, halted, snap_valid}); end
    compared++; if (step_count !== 16'd0 || val_snap !== 30'd0) begin mismatched++; $display("FAIL reset_regs: got count %0d snap %0d expected 0 0", step_count, val_snap); end
    rst_n = 1'b1;
    step_q = {5, 8, 11, 14};
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (j == 1) begin compared++; if (f_clear !== 1'b1) begin mismatched++; $display("FAIL first_clear: got %b expected 1", f_clear); end end
      if (j == 2) begin compared++; if (busy !== 1'b1 || f_clear !== 1'b0) begin mismatched++; $display("FAIL run_entry: got busy %b clear %b expected 1 0", busy, f_clear); end end
      if (f_step) begin
        compared++;
        if (step_q.size() == 0) begin mismatched++; $display("FAIL run_step: got extra step at cycle %0d expected none", j); end
        else begin e = step_q.pop_front(); if (j != e) begin mismatched++; $display("FAIL run_step: got cycle %0d expected %0d", j, e); end end
      end
      if (j == 14) begin compared++; if (step_count !== 16'd4) begin mismatched++; $display("FAIL run_count: got %0d expected 4", step_count); end end
    end
    compared++; if (step_q.size() != 0) begin mismatched++; $display("FAIL run_missing: got %0d steps missing expected 0", step_q.size()); end
  endtask

  task automatic test_single_step();
    int steps, snaps;
    longint ev;
    // Restart lands on the capture cycle of the last run step: capture cancelled.
    sw = 1'b0; rs = 1'b1;
    @(negedge clk); rs = 1'b0;
    compared++; if (f_clear !== 1'b1 || step_count !== 16'd0 || f_step !== 1'b0) begin mismatched++; $display("FAIL restart: got clear %b count %0d step %b expected 1 0 0", f_clear, step_count, f_step); end
    compared++; if (snap_valid !== 1'b0 || val_snap !== 30'd0) begin mismatched++; $display("FAIL snap_cancel: got valid %b snap %0d expected 0 0", snap_valid, val_snap); end
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL pause_busy: got %b expected 0", busy); end
    for (int p = 0; p < 3; p++) begin
      ss = 1'b1; exp_q.push_back(fib(p + 2));
      steps = 0; snaps = 0;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk); ss = 1'b0;
        if (f_step) begin steps++; compared++; if (j != 0) begin mismatched++; $display("FAIL ss_latency: got step at %0d expected 0", j); end end
        if (snap_valid) begin
          snaps++; compared++;
          if (exp_q.size() == 0) begin mismatched++; $display("FAIL ss_snap: got unexpected snap %0d expected none", val_snap); end
          else begin
            ev = exp_q.pop_front();
            if (longint'(val_snap) != ev || j != 2) begin mismatched++; $display("FAIL ss_snap: got %0d at %0d expected %0d at 2", val_snap, j, ev); end
          end
        end
      end
      compared++; if (steps != 1 || snaps != 1) begin mismatched++; $display("FAIL ss_count: got %0d steps %0d snaps expected 1 1", steps, snaps); end
    end
    compared++; if (exp_q.size() != 0 || step_count !== 16'd3) begin mismatched++; $display("FAIL ss_total: got pending %0d count %0d expected 0 3", exp_q.size(), step_count); end
  endtask

  task automatic test_clock_op();
    int steps, e;
    int step_q[$];
    cop = 6'd0; sw = 1'b1; steps = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (f_step) steps++;
      if (j == 1) begin compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL op0_busy: got %b expected 1", busy); end end
    end
    compared++; if (steps != 0) begin mismatched++; $display("FAIL op0_steps: got %0d expected 0", steps); end
    cop = 6'd2; step_q = {1, 3, 5, 7};
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (f_step) begin
        compared++;
        if (step_q.size() == 0) begin mismatched++; $display("FAIL op2_step: got extra at %0d expected none", j); end
        else begin e = step_q.pop_front(); if (j != e) begin mismatched++; $display("FAIL op2_step: got %0d expected %0d", j, e); end end
      end
    end
    compared++; if (step_q.size() != 0) begin mismatched++; $display("FAIL op2_missing: got %0d missing expected 0", step_q.size()); end
    cop = 6'd10; steps = 0;
    repeat (3) begin @(negedge clk); if (f_step) steps++; end
    cop = 6'd1;
    @(negedge clk);
    compared++; if (steps != 0 || f_step !== 1'b1) begin mismatched++; $display("FAIL op_lower: got early %0d step %b expected 0 1", steps, f_step); end
  endtask

  task automatic test_overflow();
    int steps, n, lost;
    bit done;
    rs = 1'b1; sw = 1'b1; cop = 6'd2;
    @(negedge clk); rs = 1'b0;
    compared++; if (f_clear !== 1'b1) begin mismatched++; $display("FAIL ovf_clear: got %b expected 1", f_clear); end
    steps = 0; n = 0; done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk); n++;
      if (f_step) steps++;
      if (halted) done = 1'b1;
    end
    compared++; if (!done) begin mismatched++; $display("FAIL ovf_timeout: got halted %b expected 1", halted); end
    compared++; if (steps != 43 || step_count !== 16'd43) begin mismatched++; $display("FAIL ovf_steps: got %0d count %0d expected 43 43", steps, step_count); end
    compared++; if (f_step !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL ovf_entry: got step %b busy %b expected 0 0", f_step, busy); end
    steps = 0; lost = 0;
    for (int j = 0; j < 10; j++) begin
      ss = (j % 2 == 0); sw = (j % 3 == 0);
      @(negedge clk);
      if (f_step) steps++;
      if (!halted) lost++;
    end
    ss = 1'b0;
    compared++; if (steps != 0 || lost != 0) begin mismatched++; $display("FAIL halt_ignore: got %0d steps %0d unhalted expected 0 0", steps, lost); end
    rs = 1'b1; sw = 1'b1;
    @(negedge clk); rs = 1'b0;
    compared++; if (f_clear !== 1'b1 || step_count !== 16'd0 || halted !== 1'b0) begin mismatched++; $display("FAIL halt_restart: got clear %b count %0d halted %b expected 1 0 0", f_clear, step_count, halted); end
    n = 0;
    while (!f_step && n < 10) begin @(negedge clk); n++; end
    compared++; if (f_step !== 1'b1) begin mismatched++; $display("FAIL halt_resume: got %b expected 1", f_step); end
  endtask

  task automatic test_simultaneous();
    int n, steps;
    n = 0;
    while (!f_step && n < 20) begin @(negedge clk); n++; end
    compared++; if (f_step !== 1'b1) begin mismatched++; $display("FAIL sim_sync: got %b expected 1", f_step); end
    cop = 6'd3;
    repeat (2) @(negedge clk);
    rs = 1'b1;
    @(negedge clk); rs = 1'b0;
    compared++; if (f_step !== 1'b0 || f_clear !== 1'b1) begin mismatched++; $display("FAIL restart_tick: got step %b clear %b expected 0 1", f_step, f_clear); end
    n = 0;
    while (!f_step && n < 20) begin @(negedge clk); n++; end
    compared++; if (f_step !== 1'b1) begin mismatched++; $display("FAIL sim_sync2: got %b expected 1", f_step); end
    repeat (2) @(negedge clk);
    sw = 1'b0;
    @(negedge clk);
    compared++; if (f_step !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL pause_tick: got step %b busy %b expected 0 0", f_step, busy); end
    steps = 0;
    repeat (6) begin @(negedge clk); if (f_step) steps++; end
    compared++; if (steps != 0) begin mismatched++; $display("FAIL pause_quiet: got %0d expected 0", steps); end
    sw = 1'b1;
    repeat (5) @(negedge clk);
    compared++; if (busy !== 1'b1 || step_count === 16'd0) begin mismatched++; $display("FAIL pre_reset: got busy %b count %0d expected 1 nonzero", busy, step_count); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if ({f_step, f_clear, busy, halted, snap_valid} !== 5'b0 || step_count !== 16'd0 || val_snap !== 30'd0) begin mismatched++; $display("FAIL async_reset: got flags %b count %0d snap %0d expected 0", {f_step, f_clear, busy, halted, snap_valid}, step_count, val_snap); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    compared++; if (f_clear !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL reset_clear: got clear %b busy %b expected 1 0", f_clear, busy); end
    @(negedge clk);
    compared++; if (f_clear !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL reset_run: got clear %b busy %b expected 0 1", f_clear, busy); end
  endtask

  task automatic test_saturate();
    int steps;
    steps = 0;
    rst4_n = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (f_step4) steps++;
      if (j == 1) begin compared++; if (f_clear4 !== 1'b1) begin mismatched++; $display("FAIL sat_clear: got %b expected 1", f_clear4); end end
      if (j == 2) begin compared++; if (busy4 !== 1'b1) begin mismatched++; $display("FAIL sat_busy: got %b expected 1", busy4); end end
    end
    compared++; if (steps != 28 || f_step4 !== 1'b1) begin mismatched++; $display("FAIL sat_steps: got %0d last %b expected 28 1", steps, f_step4); end
    compared++; if (step_count4 !== 4'd15) begin mismatched++; $display("FAIL sat_count: got %0d expected 15", step_count4); end
    compared++; if (halted4 !== 1'b0 || val_snap4 !== 30'd0 || snap_valid4 !== 1'b1) begin mismatched++; $display("FAIL sat_misc: got halted %b snap %0d valid %b expected 0 0 1", halted4, val_snap4, snap_valid4); end
  endtask

  initial begin
    rst_n = 1'b0; sw = 1'b1; cop = 6'd3; ss = 1'b0; rs = 1'b0;
    rst4_n = 1'b0; sw4 = 1'b1; cop4 = 6'd1; ss4 = 1'b0; rs4 = 1'b0; ovf4 = 1'b0;
    val4 = {VW{1'b0}};
    test_reset();
    test_single_step();
    test_clock_op();
    test_overflow();
    test_simultaneous();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fib_step_sequencer.md
# fib_step_sequencer

Run-control sequencer for the Fibonacci datapath. It turns the Wishbone-programmed run switch and clock-select value into single-cycle step and clear pulses for the Fibonacci core. It supports free-run at a programmable rate, paused single-stepping, overflow halt and restart. It also counts steps and snapshots the core value after each step for the register block to read back.

## Interface
- CLOCK_WIDTH, 6: width of `clock_op` and of the internal divider counter.
- VAL_WIDTH, 30: width of the Fibonacci value bus.
- STEP_WIDTH, 16: width of the step counter.

- wb_clk_i  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- switch_in  in  1  run switch from the register block (1 = free-run, 0 = pause).
- clock_op  in  CLOCK_WIDTH  step period in clocks; 0 = no automatic steps.
- single_step  in  1  one-cycle request for one step; honoured only in PAUSE.
- restart  in  1  one-cycle request to clear the core and counters.
- fib_val  in  VAL_WIDTH  current core value.
- fib_ovf  in  1  core flag: the next step would overflow VAL_WIDTH.
- fib_step  out  1  one-cycle pulse; the core advances one term.
- fib_clear  out  1  one-cycle pulse; the core reloads its seed (0,1).
- busy  out  1  high while in RUN.
- halted  out  1  high while in HALT.
- step_count  out  STEP_WIDTH  steps issued since the last clear; saturating.
- val_snap  out  VAL_WIDTH  `fib_val` captured after the most recent step.
- snap_valid  out  1  one-cycle pulse when `val_snap` updates.

## Operation
- All outputs are registered.
- While `reset_n` is low:
  - state = CLEAR;
  - all outputs = 0;
  - div_cnt = 0.
- CLEAR (one cycle):
  - fib_clear <= 1;
  - step_count <= 0, div_cnt <= 0, val_snap <= 0;
  - next state is RUN if `switch_in` = 1, otherwise PAUSE.
- RUN:
  - If clock_op = 0: div_cnt holds at 0 and no step is issued.
  - Else, if div_cnt >= clock_op-1 (tick): div_cnt <= 0.
    - If fib_ovf = 1: go to HALT and issue no step.
    - Otherwise: fib_step <= 1 and step_count increments.
  - Else: div_cnt increments.
  - The `>=` compare means that lowering `clock_op` mid-period fires on the next cycle; no wrap-around wait.
  - switch_in = 0 goes to PAUSE with div_cnt <= 0. The pause takes priority over a tick in the same cycle.
- PAUSE:
  - single_step = 1 with fib_ovf = 0: fib_step <= 1 and step_count increments.
  - single_step = 1 with fib_ovf = 1: go to HALT.
  - switch_in = 1: go to RUN with div_cnt = 0. A simultaneous `single_step` is ignored.
- HALT:
  - No steps are issued.
  - `switch_in` and `single_step` are ignored.
  - Only `restart` exits.
- `restart` takes priority over every other input in every state and goes to CLEAR next cycle. A step decided in the same cycle is dropped.
- step_count saturates at 2^STEP_WIDTH-1. Further steps are still issued; the counter holds.
- Snapshot: in the cycle after fib_step is high, the core output has updated. At the end of that cycle, val_snap <= fib_val and snap_valid <= 1 for one cycle.
  - A restart landing between a step and its capture cancels the capture.
- busy = (state == RUN); halted = (state == HALT).

## Timing
- Reset deasserts asynchronously → fib_clear is high in the first clock after the first rising edge → RUN/PAUSE begins the following cycle.
- In RUN with clock_op = N (N >= 1):
  - fib_step pulses every N cycles;
  - the first pulse comes N cycles after entering RUN;
  - N = 1 gives a step every cycle.
- single_step at edge k → fib_step high in cycle k+1 → snap_valid and val_snap updated in cycle k+3 (the captured value is the one present during cycle k+2).
- restart at edge k → fib_clear high in cycle k+1 → step_count reads 0 in cycle k+1.
- fib_step and fib_clear are never high in the same cycle.

## Test plan
- Reset release with switch_in = 1, clock_op = 3:
  - one fib_clear pulse, then fib_step every 3 cycles;
  - step_count = 4 after the 4th pulse;
  - busy = 1.
- switch_in = 0, then three single_step pulses spaced 5 cycles apart:
  - exactly 3 fib_step pulses, each 1 cycle after its request;
  - snap_valid 2 cycles after each step, with val_snap equal to the core value (1, 2, 3 with a model core seeded (0,1)).
- RUN with clock_op = 0:
  - no fib_step for 100 cycles;
  - setting clock_op = 2 gives steps every 2 cycles;
  - changing clock_op 10→1 mid-period steps on the next cycle.
- Model core with fib_ovf asserted at term 45 (VAL_WIDTH = 30):
  - goes to HALT with no step issued at overflow;
  - halted = 1;
  - single_step and switch toggles ignored;
  - restart → fib_clear, step_count = 0, resumes.
- Simultaneous events:
  - restart coincident with a RUN tick → no fib_step, fib_clear next cycle;
  - switch_in 1→0 on a tick cycle → no step;
  - reset_n pulsed low mid-RUN → all outputs 0 immediately (asynchronous), then the CLEAR sequence.
- STEP_WIDTH = 4 override, clock_op = 1:
  - step_count saturates at 15 while fib_step keeps pulsing.
